// File: rtl/wb_pkg.sv
// Shared Wishbone B3 definitions: cycle/burst type codes, responder FSM states
// and the burst wrap mask helper.
package wb_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SINGLE = 2'd1,
        ST_BURST  = 2'd2
    } wb_state_e;

    // Low index bits that advance within a wrapping burst.
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        logic [3:0] mask;
        case (bte)
            BTE_WRAP4: mask = 4'b0011;
            BTE_WRAP8: mask = 4'b0111;
            default:   mask = 4'b1111;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/wb_burst_addr.sv
// Next word index of an incrementing Wishbone burst: linear, or wrapping on a
// 4/8/16-word boundary with the upper index bits held.
module wb_burst_addr
    import wb_pkg::*;
#(
    parameter int IDX_W = 31
) (
    input  logic [IDX_W-1:0] idx_i,
    input  logic [1:0]       bte_i,
    output logic [IDX_W-1:0] next_idx_o
);

    logic [IDX_W-1:0] inc;
    logic [IDX_W-1:0] mask;

    always_comb begin
        inc  = idx_i + IDX_W'(1);
        mask = '1;
        if (bte_i != BTE_LINEAR) begin
            mask = IDX_W'(wrap_mask(bte_i));
        end
        next_idx_o = (idx_i & ~mask) | (inc & mask);
    end

endmodule

// File: rtl/wb_sram_slave.sv
// Wishbone B3 memory responder: classic cycles and registered-feedback
// incrementing bursts, byte-lane writes, error response outside the array.
module wb_sram_slave
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_WORDS  = 1024
) (
    input  logic                    CLK_I,
    input  logic                    RST_I,
    input  logic                    CYC_I,
    input  logic                    STB_I,
    input  logic                    WE_I,
    input  logic [ADDR_WIDTH-1:0]   ADR_I,
    input  logic [DATA_WIDTH-1:0]   DAT_I,
    input  logic [DATA_WIDTH/8-1:0] SEL_I,
    input  logic [2:0]              CTI_I,
    input  logic [1:0]              BTE_I,
    output logic [DATA_WIDTH-1:0]   DAT_O,
    output logic                    ACK_O,
    output logic                    ERR_O
);

    localparam int unsigned BYTES  = DATA_WIDTH / 8;
    localparam int          SHIFT  = $clog2(BYTES);
    localparam int          IDX_W  = ADDR_WIDTH - SHIFT;
    localparam int          MEM_AW = $clog2(MEM_WORDS);
    localparam logic [IDX_W-1:0] MEM_LIMIT = IDX_W'(MEM_WORDS);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

    wb_state_e             state_q, state_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] dat_q, dat_d;

    logic [IDX_W-1:0]      adr_idx;
    logic [IDX_W-1:0]      next_idx;
    logic                  adr_ok;
    logic                  next_ok;
    logic [DATA_WIDTH-1:0] rd_cur;
    logic [DATA_WIDTH-1:0] rd_next;
    logic                  beat_done;
    logic                  mem_we;
    logic [MEM_AW-1:0]     mem_waddr;
    logic                  unused_adr;

    assign adr_idx    = ADR_I[ADDR_WIDTH-1:SHIFT];
    assign unused_adr = ^{1'b0, ADR_I};
    assign adr_ok     = adr_idx < MEM_LIMIT;
    assign next_ok    = next_idx < MEM_LIMIT;
    assign rd_cur     = mem[adr_idx[MEM_AW-1:0]];
    assign rd_next    = mem[next_idx[MEM_AW-1:0]];

    assign ACK_O     = ack_q & CYC_I & STB_I;
    assign ERR_O     = err_q & CYC_I & STB_I;
    assign DAT_O     = dat_q;
    assign beat_done = ACK_O | ERR_O;

    wb_burst_addr #(
        .IDX_W (IDX_W)
    ) u_burst_addr (
        .idx_i      (idx_q),
        .bte_i      (BTE_I),
        .next_idx_o (next_idx)
    );

    always_comb begin
        state_d   = state_q;
        ack_d     = ack_q;
        err_d     = err_q;
        idx_d     = idx_q;
        dat_d     = dat_q;
        mem_we    = 1'b0;
        mem_waddr = idx_q[MEM_AW-1:0];

        if (!CYC_I) begin
            state_d = ST_IDLE;
            ack_d   = 1'b0;
            err_d   = 1'b0;
            dat_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (STB_I) begin
                        idx_d = adr_idx;
                        dat_d = adr_ok ? rd_cur : '0;
                        if (!adr_ok) begin
                            err_d   = 1'b1;
                            state_d = ST_SINGLE;
                        end else begin
                            ack_d   = 1'b1;
                            state_d = (CTI_I == CTI_INCR) ? ST_BURST : ST_SINGLE;
                        end
                    end
                end
                ST_SINGLE: begin
                    if (beat_done) begin
                        mem_we  = WE_I & ack_q;
                        ack_d   = 1'b0;
                        err_d   = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
                ST_BURST: begin
                    // Read data for the following beat is fetched on this
                    // completion edge; a linear burst running past the array
                    // answers its remaining beats with ERR.
                    if (beat_done) begin
                        mem_we = WE_I & ack_q;
                        idx_d  = next_idx;
                        dat_d  = next_ok ? rd_next : '0;
                        ack_d  = next_ok;
                        err_d  = ~next_ok;
                        if (CTI_I == CTI_END) begin
                            ack_d   = 1'b0;
                            err_d   = 1'b0;
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    ack_d   = 1'b0;
                    err_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_I) begin
            state_q <= ST_IDLE;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
        end
    end

    // Array is not reset; a write pending during reset is dropped.
    always_ff @(posedge CLK_I) begin
        if (RST_I && mem_we) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
                if (SEL_I[b]) begin
                    mem[mem_waddr][b*8 +: 8] <= DAT_I[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_sram_slave.sv
// Self-checking bench for wb_sram_slave: directed scenarios plus randomized
// bursts scored against a word-array reference model.
module tb_wb_sram_slave;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam int MW = 1024;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cyc, stb, we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat_w;
    logic [1:0]    sel;
    logic [2:0]    cti;
    logic [1:0]    bte;
    logic [DW-1:0] dat_r;
    logic          ack, err;

    always #5 clk = ~clk;

    wb_sram_slave #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MEM_WORDS  (MW)
    ) dut (
        .CLK_I (clk),
        .RST_I (rst_n),
        .CYC_I (cyc),
        .STB_I (stb),
        .WE_I  (we),
        .ADR_I (adr),
        .DAT_I (dat_w),
        .SEL_I (sel),
        .CTI_I (cti),
        .BTE_I (bte),
        .DAT_O (dat_r),
        .ACK_O (ack),
        .ERR_O (err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] ref_mem [MW];
    bit          ref_ok  [MW];

    logic [15:0] wdata   [32];
    logic [15:0] obs_dat [32];
    int          obs_rsp [32];   // 0 timeout, 1 ACK, 2 ERR
    int          obs_lat [32];
    bit          obs_gap_ok, obs_idle_ok;
    logic [15:0] obs_abort_dat;
    logic        obs_abort_ack, obs_abort_err;

    // Word visited at beat k of an access sequence.
    function automatic int exp_word(input int start, input int bte_v, input bit classic, input int k);
        int n;
        if (classic || bte_v == 0) return start + k;
        n = 2 << bte_v;
        return (start - start % n) + (start % n + k) % n;
    endfunction

    // Master driver: records response kind, latency and read data per beat.
    task automatic do_burst(input int start, input int bte_v, input int n, input bit wr,
                            input bit classic, input logic [1:0] sl, input int gap_at,
                            input int gap_len, input int abort_at, input bit abort_rst);
        int          lat;
        bit          got;
        logic [15:0] held;
        obs_gap_ok  = 1'b1;
        obs_idle_ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            cyc   = 1'b1;
            stb   = 1'b1;
            we    = wr;
            adr   = AW'((start + k) * 2);
            dat_w = wdata[k];
            sel   = sl;
            bte   = 2'(bte_v);
            cti   = classic ? 3'b000 : ((k == n - 1) ? 3'b111 : 3'b010);
            if (k == abort_at) begin
                if (abort_rst) rst_n = 1'b0;
                else cyc = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                cyc   = 1'b0;
                stb   = 1'b0;
                obs_abort_ack = ack;
                obs_abort_err = err;
                obs_abort_dat = dat_r;
                return;
            end
            lat = 0;
            got = 1'b0;
            while (!got && lat < 8) begin
                @(negedge clk);
                if (ack || err) got = 1'b1;
                else lat++;
            end
            obs_rsp[k] = !got ? 0 : (ack ? 1 : 2);
            obs_dat[k] = dat_r;
            obs_lat[k] = lat;
            @(posedge clk); #1;
            if (k == gap_at && k < n - 1) begin
                stb  = 1'b0;
                held = dat_r;
                for (int g = 0; g < gap_len; g++) begin
                    @(negedge clk);
                    if (ack || err || dat_r !== held) obs_gap_ok = 1'b0;
                    @(posedge clk); #1;
                end
            end
        end
        // Offer a new read straight away: the responder must not answer it yet.
        we  = 1'b0;
        cti = 3'b000;
        @(negedge clk);
        if (ack || err) obs_idle_ok = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b0;
        stb = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc   = 1'b1;
        stb   = 1'b1;
        we    = 1'b1;
        adr   = AW'($urandom_range(0, 2047));
        dat_w = 16'($urandom);
        sel   = 2'b11;
        cti   = 3'b010;
        bte   = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (dat_r !== 16'h0000) begin n_fail++; $display("FAIL reset_dat got=%h exp=0000", dat_r); end
        n_checks++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ack); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
        cyc   = 1'b0;
        stb   = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_classic();
        logic [15:0] saved [3];
        wdata[0] = 16'hBEEF;
        do_burst(8, 0, 1, 1'b1, 1'b1, 2'b11, -1, 0, -1, 1'b0);
        n_checks++; if (obs_rsp[0] !== 1) begin n_fail++; $display("FAIL classic_wr_rsp got=%0d exp=1", obs_rsp[0]); end
        n_checks++; if (obs_lat[0] !== 1) begin n_fail++; $display("FAIL classic_wr_lat got=%0d exp=1", obs_lat[0]); end
        n_checks++; if (obs_idle_ok !== 1'b1) begin n_fail++; $display("FAIL classic_wr_one_ack got=extra exp=none"); end
        do_burst(8, 0, 1, 1'b0, 1'b1, 2'b11, -1, 0, -1, 1'b0);
        n_checks++; if (obs_rsp[0] !== 1) begin n_fail++; $display("FAIL classic_rd_rsp got=%0d exp=1", obs_rsp[0]); end
        n_checks++; if (obs_dat[0] !== 16'hBEEF) begin n_fail++; $display("FAIL classic_rd_dat got=%h exp=beef", obs_dat[0]); end
        n_checks++; if (obs_idle_ok !== 1'b1) begin n_fail++; $display("FAIL classic_rd_one_ack got=extra exp=none"); end
        for (int k = 0; k < 3; k++) begin
            saved[k] = 16'($urandom);
            wdata[k] = saved[k];
        end
        do_burst(20, 0, 3, 1'b1, 1'b1, 2'b11, -1, 0, -1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (obs_lat[k] !== 1) begin n_fail++; $display("FAIL b2b_wr_lat[%0d] got=%0d exp=1", k, obs_lat[k]); end
        end
        do_burst(20, 0, 3, 1'b0, 1'b1, 2'b11, -1, 0, -1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_checks++; if (obs_lat[k] !== 1) begin n_fail++; $display("FAIL b2b_rd_lat[%0d] got=%0d exp=1", k, obs_lat[k]); end
            n_checks++; if (obs_dat[k] !== saved[k]) begin n_fail++; $display("FAIL b2b_rd_dat[%0d] got=%h exp=%h", k, obs_dat[k], saved[k]); end
        end
    endtask

    task automatic test_linear();
        for (int k = 0; k < 6; k++) wdata[k] = 16'(k + 1);
        do_burst(0, 0, 6, 1'b1, 1'b0, 2'b11, -1, 0, -1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (obs_rsp[k] !== 1) begin n_fail++; $display("FAIL lin_wr_rsp[%0d] got=%0d exp=1", k, obs_rsp[k]); end
            n_checks++; if (obs_lat[k] !== ((k == 0) ? 1 : 0)) begin n_fail++; $display("FAIL lin_wr_lat[%0d] got=%0d exp=%0d", k, obs_lat[k], (k == 0) ? 1 : 0); end
        end
        n_checks++; if (obs_idle_ok !== 1'b1) begin n_fail++; $display("FAIL lin_wr_end got=extra-ack exp=none"); end
        do_burst(0, 0, 6, 1'b0, 1'b0, 2'b11, -1, 0, -1, 1'b0);
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (obs_dat[k] !== 16'(k + 1)) begin n_fail++; $display("FAIL lin_rd_dat[%0d] got=%h exp=%h", k, obs_dat[k], 16'(k + 1)); end
        end
    endtask

    task automatic test_wait_states();
        do_burst(0, 0, 6, 1'b0, 1'b0, 2'b11, 2, 2, -1, 1'b0);
        n_checks++; if (obs_gap_ok !== 1'b1) begin n_fail++; $display("FAIL wait_hold got=ack-or-dat-change exp=held"); end
        n_checks++; if (obs_lat[3] !== 0) begin n_fail++; $display("FAIL wait_resume_lat got=%0d exp=0", obs_lat[3]); end
        for (int k = 0; k < 6; k++) begin
            n_checks++; if (obs_dat[k] !== 16'(k + 1)) begin n_fail++; $display("FAIL wait_dat[%0d] got=%h exp=%h", k, obs_dat[k], 16'(k + 1)); end
        end
    endtask

    task automatic test_wrap4();
        int order [4] = '{6, 7, 4, 5};
        for (int k = 0; k < 4; k++) wdata[k] = 16'(16'h4440 + 4 + k);
        do_burst(4, 0, 4, 1'b1, 1'b0, 2'b11, -1, 0, -1, 1'b0);
        do_burst(6, 1, 4, 1'b0, 1'b0, 2'b11, -1, 0, -1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (obs_dat[k] !== 16'(16'h4440 + order[k])) begin n_fail++; $display("FAIL wrap4_dat[%0d] got=%h exp=%h", k, obs_dat[k], 16'(16'h4440 + order[k])); end
        end
    endtask

    task automatic test_byte_lanes_err();
        wdata[0] = 16'hFFFF;
        do_burst(40, 0, 1, 1'b1, 1'b1, 2'b11, -1, 0, -1, 1'b0);
        wdata[0] = 16'h1234;
        do_burst(40, 0, 1, 1'b1, 1'b1, 2'b01, -1, 0, -1, 1'b0);
        do_burst(40, 0, 1, 1'b0, 1'b1, 2'b11, -1, 0, -1, 1'b0);
        n_checks++; if (obs_dat[0] !== 16'hFF34) begin n_fail++; $display("FAIL lane_dat got=%h exp=ff34", obs_dat[0]); end
        do_burst(MW, 0, 1, 1'b0, 1'b1, 2'b11, -1, 0, -1, 1'b0);
        n_checks++; if (obs_rsp[0] !== 2) begin n_fail++; $display("FAIL err_rd_rsp got=%0d exp=2", obs_rsp[0]); end
        n_checks++; if (obs_lat[0] !== 1) begin n_fail++; $display("FAIL err_rd_lat got=%0d exp=1", obs_lat[0]); end
        n_checks++; if (obs_idle_ok !== 1'b1) begin n_fail++; $display("FAIL err_one_cycle got=extra exp=none"); end
        wdata[0] = 16'hDEAD;
        do_burst(MW, 0, 1, 1'b1, 1'b1, 2'b11, -1, 0, -1, 1'b0);
        n_checks++; if (obs_rsp[0] !== 2) begin n_fail++; $display("FAIL err_wr_rsp got=%0d exp=2", obs_rsp[0]); end
        for (int k = 0; k < 4; k++) wdata[k] = 16'(16'hC000 + k);
        do_burst(MW - 2, 0, 4, 1'b1, 1'b0, 2'b11, -1, 0, -1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++; if (obs_rsp[k] !== ((k < 2) ? 1 : 2)) begin n_fail++; $display("FAIL cross_rsp[%0d] got=%0d exp=%0d", k, obs_rsp[k], (k < 2) ? 1 : 2); end
        end
        do_burst(MW - 2, 0, 2, 1'b0, 1'b1, 2'b11, -1, 0, -1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (obs_dat[k] !== 16'(16'hC000 + k)) begin n_fail++; $display("FAIL cross_rd[%0d] got=%h exp=%h", k, obs_dat[k], 16'(16'hC000 + k)); end
        end
        do_burst(0, 0, 2, 1'b0, 1'b1, 2'b11, -1, 0, -1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            n_checks++; if (obs_dat[k] !== 16'(k + 1)) begin n_fail++; $display("FAIL err_no_write[%0d] got=%h exp=%h", k, obs_dat[k], 16'(k + 1)); end
        end
    endtask

    task automatic test_abort();
        logic [15:0] expv [4];
        for (int mode = 0; mode < 2; mode++) begin
            for (int k = 0; k < 4; k++) wdata[k] = 16'(16'hA000 + k);
            do_burst(0, 0, 4, 1'b1, 1'b0, 2'b11, -1, 0, -1, 1'b0);
            for (int k = 0; k < 4; k++) wdata[k] = 16'(16'hB000 + k);
            do_burst(0, 0, 4, 1'b1, 1'b0, 2'b11, -1, 0, 2, mode[0]);
            n_checks++; if (obs_abort_ack !== 1'b0) begin n_fail++; $display("FAIL abort%0d_ack got=%b exp=0", mode, obs_abort_ack); end
            n_checks++; if (obs_abort_err !== 1'b0) begin n_fail++; $display("FAIL abort%0d_err got=%b exp=0", mode, obs_abort_err); end
            n_checks++; if (obs_abort_dat !== 16'h0000) begin n_fail++; $display("FAIL abort%0d_dat got=%h exp=0000", mode, obs_abort_dat); end
            do_burst(0, 0, 4, 1'b0, 1'b1, 2'b11, -1, 0, -1, 1'b0);
            expv = '{16'hB000, 16'hB001, 16'hA002, 16'hA003};
            n_checks++; if (obs_lat[0] !== 1) begin n_fail++; $display("FAIL abort%0d_restart_lat got=%0d exp=1", mode, obs_lat[0]); end
            for (int k = 0; k < 4; k++) begin
                n_checks++; if (obs_dat[k] !== expv[k]) begin n_fail++; $display("FAIL abort%0d_dat[%0d] got=%h exp=%h", mode, k, obs_dat[k], expv[k]); end
            end
        end
    endtask

    task automatic test_random_bursts();
        int          start, bte_v, n, gap_at, gap_len, w;
        bit          wr, classic;
        logic [1:0]  sl;
        for (int blk = 0; blk < 4; blk++) begin
            for (int k = 0; k < 16; k++) wdata[k] = 16'($urandom);
            do_burst(blk * 16, 0, 16, 1'b1, 1'b0, 2'b11, -1, 0, -1, 1'b0);
            for (int k = 0; k < 16; k++) begin
                ref_mem[blk * 16 + k] = wdata[k];
                ref_ok[blk * 16 + k]  = 1'b1;
            end
        end
        for (int it = 0; it < 30; it++) begin
            bte_v   = $urandom_range(0, 3);
            classic = ($urandom_range(0, 3) == 0);
            wr      = $urandom_range(0, 1) == 1;
            sl      = 2'($urandom_range(1, 3));
            if (classic) n = $urandom_range(1, 3);
            else if (bte_v == 0) n = $urandom_range(1, 8);
            else n = $urandom_range(1, 2 << bte_v);
            start   = ($urandom_range(0, 4) == 0) ? $urandom_range(MW - 6, MW - 1) : $urandom_range(0, 63);
            gap_at  = classic ? -1 : $urandom_range(0, n);
            gap_len = $urandom_range(1, 3);
            for (int k = 0; k < n; k++) wdata[k] = 16'($urandom);
            do_burst(start, bte_v, n, wr, classic, sl, gap_at, gap_len, -1, 1'b0);
            for (int k = 0; k < n; k++) begin
                w = exp_word(start, bte_v, classic, k);
                n_checks++; if (obs_rsp[k] !== ((w < MW) ? 1 : 2)) begin n_fail++; $display("FAIL rnd%0d_rsp[%0d] got=%0d exp=%0d", it, k, obs_rsp[k], (w < MW) ? 1 : 2); end
                n_checks++; if (obs_lat[k] !== ((classic || k == 0) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_lat[%0d] got=%0d exp=%0d", it, k, obs_lat[k], (classic || k == 0) ? 1 : 0); end
                if (!wr && w < MW && ref_ok[w]) begin
                    n_checks++; if (obs_dat[k] !== ref_mem[w]) begin n_fail++; $display("FAIL rnd%0d_dat[%0d] word=%0d got=%h exp=%h", it, k, w, obs_dat[k], ref_mem[w]); end
                end
                if (wr && w < MW) begin
                    if (sl[0]) ref_mem[w][7:0]  = wdata[k][7:0];
                    if (sl[1]) ref_mem[w][15:8] = wdata[k][15:8];
                    if (sl == 2'b11) ref_ok[w] = 1'b1;
                end
            end
            n_checks++; if (obs_idle_ok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_end got=extra-ack exp=none", it); end
            if (gap_at >= 0 && gap_at < n - 1) begin
                n_checks++; if (obs_gap_ok !== 1'b1) begin n_fail++; $display("FAIL rnd%0d_gap got=ack-or-dat-change exp=held", it); end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        adr   = '0;
        dat_w = '0;
        sel   = '0;
        cti   = '0;
        bte   = '0;
        for (int i = 0; i < MW; i++) ref_ok[i] = 1'b0;
        test_reset();
        test_classic();
        test_linear();
        test_wait_states();
        test_wrap4();
        test_byte_lanes_err();
        test_abort();
        test_random_bursts();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_sram_slave.md
# wb_sram_slave

Synthesizable Wishbone B3 responder with on-chip word memory, the slave-side counterpart of the MAM Wishbone initiator (`mam_wb_if`). It serves classic single cycles and registered-feedback incrementing bursts (linear and wrapping), with byte-lane write enables and an error response for out-of-range addresses. It is the memory target in MAM system benches and in small SoC configurations.

## Interface
- DATA_WIDTH, 16, data bus width in bits (multiple of 8)
- ADDR_WIDTH, 32, byte address width
- MEM_WORDS, 1024, memory depth in DATA_WIDTH words (power of two)
- CLK_I  in  1  clock; all logic on rising edge
- RST_I  in  1  reset; synchronous, active-low
- CYC_I  in  1  bus cycle active
- STB_I  in  1  strobe, current beat valid
- WE_I  in  1  1 = write, 0 = read
- ADR_I  in  ADDR_WIDTH  byte address
- DAT_I  in  DATA_WIDTH  write data
- SEL_I  in  DATA_WIDTH/8  byte-lane write enables
- CTI_I  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
- BTE_I  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- DAT_O  out  DATA_WIDTH  read data, valid while ACK_O
- ACK_O  out  1  normal termination
- ERR_O  out  1  error termination

## Operation
- Word index = ADR_I >> log2(DATA_WIDTH/8); in range iff index < MEM_WORDS (upper address bits must be zero).
- FSM states IDLE, SINGLE, BURST; internal `ack_q`, `err_q`, word-index register `idx`.
- ACK_O = ack_q & CYC_I & STB_I; ERR_O = err_q & CYC_I & STB_I. A beat completes on an edge where ACK_O or ERR_O is 1.
- IDLE: on CYC_I & STB_I, latch idx from ADR_I and load DAT_O = mem[idx]. Out of range: set err_q and go to SINGLE. Otherwise set ack_q; CTI_I=010 goes to BURST, any other CTI goes to SINGLE.
- SINGLE: wait for beat completion. Write beat: mem[idx] updated per SEL_I lane. Then clear ack_q/err_q and return to IDLE, giving one dead cycle.
- BURST, on each completed beat:
  - write mem[idx] per SEL_I;
  - idx ← next index per BTE_I (linear: idx+1; wrapN: low log2(N) bits increment modulo N, upper bits held);
  - DAT_O ← mem[next idx];
  - if CTI_I=111 on that beat, clear ack_q and go to IDLE.
- BURST with STB_I low: wait state. idx, DAT_O and ack_q hold; no memory access.
- Linear burst crossing MEM_WORDS: the beat at the out-of-range index terminates with ERR_O instead of ACK_O, with no write. The burst continues until CTI=111.
- CYC_I low in any state: go to IDLE, clear ack_q/err_q, no write.
- Memory contents are not reset.

## Timing
- Reset values: DAT_O=0, ACK_O=0, ERR_O=0, state IDLE, idx=0. Reset mid-burst aborts it; any pending write is dropped.
- First beat: ACK/ERR one cycle after STB_I is first sampled high in IDLE.
- Classic access occupies 2 cycles; back-to-back classic accesses complete every 2 cycles.
- Burst: after the first-beat latency, one beat per cycle while STB_I is held high. An N-beat burst with no wait states takes N+1 cycles.
- Read data: DAT_O for beat k+1 is registered at the edge completing beat k, so it is valid in the cycle ACK_O is high.
- Write of the final beat (CTI=111) commits at that beat's completion edge. A classic read issued next sees the new data.
- Simultaneous CYC_I drop and ACK_O high: ACK_O is 0 by the gating, so no beat completes.

## Structure
- Shared package `wb_pkg`:
  - CTI constants CTI_CLASSIC=3'b000, CTI_INCR=3'b010, CTI_END=3'b111;
  - BTE constants BTE_LINEAR, BTE_WRAP4, BTE_WRAP8, BTE_WRAP16;
  - FSM state enum type.
- Sub-module `wb_burst_addr`: combinational next-index function of (idx, BTE_I). It is reused by the `mam_wb_if` upgrade.
- Memory array is inferred inside `wb_sram_slave`, with a byte-lane write loop.

## Test plan
- Classic write then read: write 16'hBEEF to byte address 0x10 with SEL=2'b11, then read 0x10. Each access: ACK high exactly 1 cycle, 2 cycles per access; DAT_O=16'hBEEF.
- Linear write burst: 6 beats of 0x0001..0x0006 from 0x0, CTI 010 for beats 1–5 and 111 for beat 6. ACK high for 6 consecutive cycles, latency 1. Read-back burst returns 0x0001..0x0006.
- Wrap4 read: start address word 6 (byte 0xC), BTE=01, 4 beats. Word order 6,7,4,5.
- Wait states: mid-burst STB low for 2 cycles. ACK low during the gap, DAT_O held, address not advanced, data sequence unchanged.
- Byte lanes and error: SEL=2'b01 write of 0x1234 over 0xFFFF gives 0xFF34. Access at word MEM_WORDS gives ERR_O for 1 cycle, no ACK, memory unchanged.
- Abort: reset or CYC drop after beat 2 of a 4-beat write burst. Only words 0–1 written; all outputs 0 next cycle; FSM accepts a new classic cycle immediately.
